// File: rtl/rc4_phase_sequencer_if.sv
// Handshake and working-memory bus between the RC4 phase sequencer and its
// load / shuffle / decrypt engines.
interface rc4_phase_sequencer_if #(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              l_start, l_done;
    logic              s_start, s_done;
    logic              dm_start, dm_done, dm_valid;
    logic [KEY_W-1:0]  key;
    logic [ADDR_W-1:0] l_address, s_address, dm_address;
    logic [DATA_W-1:0] l_data, s_data, dm_data;
    logic              l_wren, s_wren, dm_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              busy, found, exhausted;

    modport master (
        input  start, l_done, s_done, dm_done, dm_valid,
        input  l_address, l_data, l_wren, s_address, s_data, s_wren,
        input  dm_address, dm_data, dm_wren,
        output l_start, s_start, dm_start, key,
        output mem_address, mem_data, mem_wren, busy, found, exhausted
    );

    modport slave (
        output start, l_done, s_done, dm_done, dm_valid,
        output l_address, l_data, l_wren, s_address, s_data, s_wren,
        output dm_address, dm_data, dm_wren,
        input  l_start, s_start, dm_start, key,
        input  mem_address, mem_data, mem_wren, busy, found, exhausted
    );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// RC4 key-search controller: walks candidate keys through load, shuffle and
// decrypt phases and grants the single working-memory port to the active engine.
module rc4_phase_sequencer #(
    parameter int               KEY_W   = 24,
    parameter logic [KEY_W-1:0] KEY_MAX = KEY_W'(24'h3FFFFF),
    parameter int               ADDR_W  = 8,
    parameter int               DATA_W  = 8
) (
    input logic clk,
    input logic reset_n,
    rc4_phase_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHUFFLE, S_DECRYPT, S_NEXT_KEY, S_FOUND, S_FAIL
    } state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             l_start_q, s_start_q, dm_start_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            l_start_q  <= 1'b0;
            s_start_q  <= 1'b0;
            dm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            // Start pulses mark the first cycle spent in each engine phase.
            l_start_q  <= (state_d == S_LOAD)    && (state_q != S_LOAD);
            s_start_q  <= (state_d == S_SHUFFLE) && (state_q != S_SHUFFLE);
            dm_start_q <= (state_d == S_DECRYPT) && (state_q != S_DECRYPT);
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        case (state_q)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    key_d   = '0;
                end
            end
            S_LOAD:    if (bus.l_done) state_d = S_SHUFFLE;
            S_SHUFFLE: if (bus.s_done) state_d = S_DECRYPT;
            S_DECRYPT: begin
                if (bus.dm_done) begin
                    if (bus.dm_valid)        state_d = S_FOUND;
                    else if (key_q == KEY_MAX) state_d = S_FAIL;
                    else                     state_d = S_NEXT_KEY;
                end
            end
            S_NEXT_KEY: begin
                key_d   = key_q + 1'b1;
                state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant follows the registered state so engine requests pass with no added latency.
    always_comb begin
        bus.busy        = 1'b0;
        bus.found       = 1'b0;
        bus.exhausted   = 1'b0;
        bus.mem_address = '0;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        case (state_q)
            S_LOAD: begin
                bus.busy        = 1'b1;
                bus.mem_address = bus.l_address;
                bus.mem_data    = bus.l_data;
                bus.mem_wren    = bus.l_wren;
            end
            S_SHUFFLE: begin
                bus.busy        = 1'b1;
                bus.mem_address = bus.s_address;
                bus.mem_data    = bus.s_data;
                bus.mem_wren    = bus.s_wren;
            end
            S_DECRYPT: begin
                bus.busy        = 1'b1;
                bus.mem_address = bus.dm_address;
                bus.mem_data    = bus.dm_data;
                bus.mem_wren    = bus.dm_wren;
            end
            S_NEXT_KEY: bus.busy      = 1'b1;
            S_FOUND:    bus.found     = 1'b1;
            S_FAIL:     bus.exhausted = 1'b1;
            default: ;
        endcase
    end

    assign bus.key      = key_q;
    assign bus.l_start  = l_start_q;
    assign bus.s_start  = s_start_q;
    assign bus.dm_start = dm_start_q;
endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench: full-width sequencer for the search flow, a KEY_MAX=3 copy
// for key-space exhaustion.
module tb_rc4_phase_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rc4_phase_sequencer_if #(.KEY_W(24), .ADDR_W(8), .DATA_W(8)) ia ();
    rc4_phase_sequencer_if #(.KEY_W(24), .ADDR_W(8), .DATA_W(8)) ib ();

    rc4_phase_sequencer #(.KEY_W(24), .KEY_MAX(24'h3FFFFF), .ADDR_W(8), .DATA_W(8))
        dut_a (.clk(clk), .reset_n(rst_n), .bus(ia));
    rc4_phase_sequencer #(.KEY_W(24), .KEY_MAX(24'h000003), .ADDR_W(8), .DATA_W(8))
        dut_b (.clk(clk), .reset_n(rst_n), .bus(ib));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ia.start = 0; ia.l_done = 0; ia.s_done = 0; ia.dm_done = 0; ia.dm_valid = 0;
        ia.l_address = 0; ia.l_data = 0; ia.l_wren = 0;
        ia.s_address = 0; ia.s_data = 0; ia.s_wren = 0;
        ia.dm_address = 0; ia.dm_data = 0; ia.dm_wren = 0;
        ib.start = 0; ib.l_done = 0; ib.s_done = 0; ib.dm_done = 0; ib.dm_valid = 0;
        ib.l_address = 0; ib.l_data = 0; ib.l_wren = 0;
        ib.s_address = 0; ib.s_data = 0; ib.s_wren = 0;
        ib.dm_address = 0; ib.dm_data = 0; ib.dm_wren = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ia.l_wren = 1; ia.s_wren = 1; ia.dm_wren = 1; ia.l_address = 8'hA5;
        rst_n = 0;
        step(); step();
        tests++;
        if ({ia.busy, ia.found, ia.exhausted, ia.l_start, ia.s_start, ia.dm_start} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 000000",
                {ia.busy, ia.found, ia.exhausted, ia.l_start, ia.s_start, ia.dm_start});
        end
        tests++;
        if (ia.key !== 24'h0) begin fails++; $display("FAIL reset_key: got %0h want 0", ia.key); end
        tests++;
        if (ia.mem_wren !== 1'b0 || ia.mem_address !== 8'h00) begin
            fails++; $display("FAIL reset_grant: got wren=%b addr=%0h want 0/0", ia.mem_wren, ia.mem_address);
        end
        rst_n = 1;
        clear_inputs();
        step();
    endtask

    task automatic test_single_key();
        ia.start = 1; step(); ia.start = 0;               // cycle 1: LOAD
        tests++;
        if (ia.l_start !== 1'b1 || ia.busy !== 1'b1 || ia.key !== 24'h0) begin
            fails++; $display("FAIL load_entry: got l_start=%b busy=%b key=%0h want 1 1 0", ia.l_start, ia.busy, ia.key);
        end
        step();
        tests++;
        if (ia.l_start !== 1'b0) begin fails++; $display("FAIL l_start_width: got %b want 0", ia.l_start); end
        repeat (2) step();
        ia.l_done = 1; step(); ia.l_done = 0;              // SHUFFLE
        tests++;
        if (ia.s_start !== 1'b1 || ia.l_start !== 1'b0) begin
            fails++; $display("FAIL shuffle_entry: got s_start=%b l_start=%b want 1 0", ia.s_start, ia.l_start);
        end
        step();
        tests++;
        if (ia.s_start !== 1'b0) begin fails++; $display("FAIL s_start_width: got %b want 0", ia.s_start); end
        repeat (13) step();
        ia.s_done = 1; step(); ia.s_done = 0;              // DECRYPT
        tests++;
        if (ia.dm_start !== 1'b1) begin fails++; $display("FAIL decrypt_entry: got dm_start=%b want 1", ia.dm_start); end
        step();
        tests++;
        if (ia.dm_start !== 1'b0) begin fails++; $display("FAIL dm_start_width: got %b want 0", ia.dm_start); end
        repeat (18) step();
        ia.dm_done = 1; ia.dm_valid = 1; step(); ia.dm_done = 0; ia.dm_valid = 0;
        tests++;
        if (ia.found !== 1'b1 || ia.busy !== 1'b0 || ia.key !== 24'h0) begin
            fails++; $display("FAIL found_key0: got found=%b busy=%b key=%0h want 1 0 0", ia.found, ia.busy, ia.key);
        end
        step();
        tests++;
        if (ia.found !== 1'b1 || ia.dm_start !== 1'b0) begin
            fails++; $display("FAIL found_hold: got found=%b dm_start=%b want 1 0", ia.found, ia.dm_start);
        end
    endtask

    task automatic test_key_walk();
        ia.start = 1; step(); ia.start = 0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ia.l_start !== 1'b1 || ia.key !== 24'(k)) begin
                fails++; $display("FAIL walk_load k=%0d: got l_start=%b key=%0h want 1 %0h", k, ia.l_start, ia.key, k);
            end
            ia.l_done = 1; step(); ia.l_done = 0;
            ia.s_done = 1; step(); ia.s_done = 0;          // done in same cycle as s_start
            tests++;
            if (ia.dm_start !== 1'b1 || ia.key !== 24'(k)) begin
                fails++; $display("FAIL walk_decrypt k=%0d: got dm_start=%b key=%0h want 1 %0h", k, ia.dm_start, ia.key, k);
            end
            ia.dm_done = 1; ia.dm_valid = (k == 3); step(); ia.dm_done = 0; ia.dm_valid = 0;
            if (k < 3) begin
                tests++;
                if (ia.busy !== 1'b1 || ia.l_start !== 1'b0 || ia.key !== 24'(k)) begin
                    fails++; $display("FAIL walk_nextkey k=%0d: got busy=%b l_start=%b key=%0h want 1 0 %0h",
                        k, ia.busy, ia.l_start, ia.key, k);
                end
                step();
            end
        end
        tests++;
        if (ia.found !== 1'b1 || ia.key !== 24'h3) begin
            fails++; $display("FAIL walk_found: got found=%b key=%0h want 1 3", ia.found, ia.key);
        end
    endtask

    task automatic test_mux();
        ia.l_address = 8'h11; ia.l_data = 8'h22; ia.l_wren = 1;
        ia.s_address = 8'h33; ia.s_data = 8'h44; ia.s_wren = 1;
        ia.dm_address = 8'h55; ia.dm_data = 8'h66; ia.dm_wren = 0;
        #1;
        tests++;
        if (ia.mem_address !== 8'h00 || ia.mem_data !== 8'h00 || ia.mem_wren !== 1'b0) begin
            fails++; $display("FAIL mux_found: got %0h/%0h/%b want 0/0/0", ia.mem_address, ia.mem_data, ia.mem_wren);
        end
        ia.start = 1; step(); ia.start = 0;
        tests++;
        if (ia.mem_address !== 8'h11 || ia.mem_data !== 8'h22 || ia.mem_wren !== 1'b1) begin
            fails++; $display("FAIL mux_load: got %0h/%0h/%b want 11/22/1", ia.mem_address, ia.mem_data, ia.mem_wren);
        end
        ia.l_done = 1; step(); ia.l_done = 0;
        tests++;
        if (ia.mem_address !== 8'h33 || ia.mem_data !== 8'h44 || ia.mem_wren !== 1'b1) begin
            fails++; $display("FAIL mux_shuffle: got %0h/%0h/%b want 33/44/1", ia.mem_address, ia.mem_data, ia.mem_wren);
        end
        ia.s_done = 1; step(); ia.s_done = 0;
        tests++;
        if (ia.mem_address !== 8'h55 || ia.mem_data !== 8'h66 || ia.mem_wren !== 1'b0) begin
            fails++; $display("FAIL mux_decrypt: got %0h/%0h/%b want 55/66/0", ia.mem_address, ia.mem_data, ia.mem_wren);
        end
        ia.dm_done = 1; ia.dm_valid = 1; ia.dm_wren = 1; step(); ia.dm_done = 0; ia.dm_valid = 0;
        tests++;
        if (ia.mem_address !== 8'h00 || ia.mem_wren !== 1'b0 || ia.found !== 1'b1) begin
            fails++; $display("FAIL mux_after: got addr=%0h wren=%b found=%b want 0 0 1", ia.mem_address, ia.mem_wren, ia.found);
        end
        clear_inputs();
    endtask

    task automatic test_spurious();
        ia.start = 1; step(); ia.start = 0;
        ia.l_address = 8'h77;
        ia.s_done = 1; ia.dm_done = 1; ia.dm_valid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (ia.busy !== 1'b1 || ia.found !== 1'b0 || ia.s_start !== 1'b0 || ia.dm_start !== 1'b0
                || ia.mem_address !== 8'h77) begin
                fails++; $display("FAIL spurious_hold i=%0d: got busy=%b found=%b s_start=%b dm_start=%b addr=%0h want 1 0 0 0 77",
                    i, ia.busy, ia.found, ia.s_start, ia.dm_start, ia.mem_address);
            end
        end
        ia.s_done = 0; ia.dm_done = 0; ia.dm_valid = 0;
        ia.l_done = 1; step(); ia.l_done = 0;
        tests++;
        if (ia.s_start !== 1'b1) begin fails++; $display("FAIL spurious_exit: got s_start=%b want 1", ia.s_start); end
        ia.s_done = 1; step(); ia.s_done = 0;
        ia.dm_done = 1; ia.dm_valid = 1; step(); ia.dm_done = 0; ia.dm_valid = 0;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        ia.start = 1; step(); ia.start = 0;
        for (int k = 0; k < 5; k++) begin
            ia.l_done = 1; step(); ia.l_done = 0;
            ia.s_done = 1; step(); ia.s_done = 0;
            ia.dm_done = 1; step(); ia.dm_done = 0;
            step();
        end
        tests++;
        if (ia.key !== 24'h5 || ia.l_start !== 1'b1) begin
            fails++; $display("FAIL midreset_key5: got key=%0h l_start=%b want 5 1", ia.key, ia.l_start);
        end
        ia.l_done = 1; step(); ia.l_done = 0;
        ia.s_address = 8'h5A; ia.s_wren = 1;
        step();
        rst_n = 0; step(); rst_n = 1;
        tests++;
        if (ia.key !== 24'h0 || {ia.busy, ia.found, ia.exhausted, ia.l_start, ia.s_start, ia.dm_start} !== 6'b0
            || ia.mem_wren !== 1'b0 || ia.mem_address !== 8'h00) begin
            fails++; $display("FAIL midreset_state: got key=%0h flags=%b wren=%b addr=%0h want 0 000000 0 0",
                ia.key, {ia.busy, ia.found, ia.exhausted, ia.l_start, ia.s_start, ia.dm_start}, ia.mem_wren, ia.mem_address);
        end
        ia.l_done = 1; step(); ia.l_done = 0;
        tests++;
        if (ia.busy !== 1'b0 || ia.s_start !== 1'b0) begin
            fails++; $display("FAIL midreset_idle: got busy=%b s_start=%b want 0 0", ia.busy, ia.s_start);
        end
        clear_inputs();
    endtask

    task automatic test_exhaust();
        ib.start = 1; step(); ib.start = 0;
        for (int k = 0; k < 4; k++) begin
            ib.l_done = 1; step(); ib.l_done = 0;
            ib.s_done = 1; step(); ib.s_done = 0;
            ib.dm_done = 1; ib.dm_valid = 0; step(); ib.dm_done = 0;
            if (k < 3) step();
        end
        tests++;
        if (ib.exhausted !== 1'b1 || ib.busy !== 1'b0 || ib.key !== 24'h3) begin
            fails++; $display("FAIL exhaust_state: got exhausted=%b busy=%b key=%0h want 1 0 3", ib.exhausted, ib.busy, ib.key);
        end
        repeat (3) step();
        tests++;
        if (ib.exhausted !== 1'b1 || ib.key !== 24'h3 || ib.l_start !== 1'b0) begin
            fails++; $display("FAIL exhaust_hold: got exhausted=%b key=%0h l_start=%b want 1 3 0", ib.exhausted, ib.key, ib.l_start);
        end
        ib.start = 1; step(); ib.start = 0;
        tests++;
        if (ib.exhausted !== 1'b0 || ib.busy !== 1'b1 || ib.key !== 24'h0 || ib.l_start !== 1'b1) begin
            fails++; $display("FAIL exhaust_restart: got exhausted=%b busy=%b key=%0h l_start=%b want 0 1 0 1",
                ib.exhausted, ib.busy, ib.key, ib.l_start);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_key_walk();
        test_mux();
        test_spurious();
        test_reset_mid();
        test_exhaust();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rc4_phase_sequencer.md
Name: rc4_phase_sequencer

Overview:
- Top-level controller for the RC4 key-search datapath.
- Sequences the three working-memory phases for each candidate key: load (S[i]=i), shuffle (key schedule) and decrypt-message.
- Owns the single 256x8 working memory port and grants it to exactly one phase engine at a time.
- On a failed decrypt it advances the candidate key and repeats, until a valid message is found or the key space is exhausted.

Parameters:
- KEY_W, 24, candidate key width.
- KEY_MAX, 24'h3FFFFF, last key searched (inclusive).
- ADDR_W, 8, working memory address width.
- DATA_W, 8, working memory data width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  begin search from key 0; level sampled in IDLE, FOUND, FAIL.
- l_start  out  1  one-cycle start pulse to load engine.
- l_done  in  1  one-cycle done pulse from load engine.
- s_start  out  1  one-cycle start pulse to shuffle engine.
- s_done  in  1  one-cycle done pulse from shuffle engine.
- dm_start  out  1  one-cycle start pulse to decrypt engine.
- dm_done  in  1  one-cycle done pulse from decrypt engine.
- dm_valid  in  1  decrypt result valid (all chars legal); sampled only with dm_done.
- key  out  KEY_W  current candidate key to shuffle/decrypt engines.
- l_address/l_data/l_wren, s_address/s_data/s_wren, dm_address/dm_data/dm_wren  in  ADDR_W/DATA_W/1  per-engine memory requests.
- mem_address  out  ADDR_W  working memory address.
- mem_data  out  DATA_W  working memory write data.
- mem_wren  out  1  working memory write enable.
- busy  out  1  high in LOAD, SHUFFLE, DECRYPT, NEXT_KEY.
- found  out  1  high in FOUND.
- exhausted  out  1  high in FAIL.

Behaviour:
- States: IDLE, LOAD, SHUFFLE, DECRYPT, NEXT_KEY, FOUND, FAIL. All state, key and pulse outputs are registered.
- Reset (reset_n=0 at a clk edge, including mid-search):
  - state=IDLE, key=0.
  - All *_start=0, busy=found=exhausted=0.
  - Grant=none.
- IDLE: start=1 -> LOAD with key=0.
- LOAD: l_done=1 -> SHUFFLE.
- SHUFFLE: s_done=1 -> DECRYPT.
- DECRYPT: dm_done=1 and dm_valid=1 -> FOUND; key holds the winning value.
- DECRYPT: dm_done=1, dm_valid=0, key==KEY_MAX -> FAIL.
- DECRYPT: dm_done=1, dm_valid=0, key<KEY_MAX -> NEXT_KEY.
- NEXT_KEY: exactly one cycle; key <= key+1; -> LOAD.
- FOUND / FAIL: hold, with key frozen. start=1 -> LOAD with key reset to 0.
- Start pulses: l_start/s_start/dm_start are high for exactly the first cycle spent in LOAD/SHUFFLE/DECRYPT respectively; 0 otherwise.
- A done pulse arriving in the same cycle as the matching start pulse is honoured.
- Done pulses arriving outside their own state are ignored. No state change, no error.
- dm_valid is ignored unless dm_done=1 in DECRYPT.
- Memory mux: combinational from the registered state, zero added latency on request paths.
  - LOAD selects l_* ; SHUFFLE selects s_* ; DECRYPT selects dm_*.
  - All other states: mem_address=0, mem_data=0, mem_wren=0. No engine can write outside its phase.
- key changes only on the NEXT_KEY edge, or the start-restart edge, never during SHUFFLE/DECRYPT.
- No key wrap: increment never occurs from KEY_MAX.
- Minimum per-key overhead: 1 cycle (NEXT_KEY), plus the engine latencies.

Test Plan:
- Reset, start=1 one cycle; l_done at cycle 5, s_done at cycle 20, dm_done+dm_valid=1 at cycle 40 -> l_start, s_start, dm_start each one-cycle pulses at their state entries; found=1, key=0, busy=0.
- dm_valid=0 for keys 0..2, dm_valid=1 on key 3 -> three NEXT_KEY cycles, key steps 0,1,2,3; found=1, key=3.
- KEY_MAX=3, dm_valid always 0 -> exhausted=1 with key=3, no fourth increment; start=1 then -> LOAD, key=0, exhausted=0.
- Drive l_wren=1 and s_wren=1 constantly while in DECRYPT with dm_wren=0 -> mem_wren=0. In IDLE/FOUND with any *_wren=1 -> mem_address=0, mem_wren=0.
- Spurious s_done=1 and dm_done=1 during LOAD -> state stays LOAD until l_done.
- reset_n=0 for one cycle mid-SHUFFLE at key 5 -> next cycle IDLE, key=0, all outputs 0.
